// File: rtl/shift_pkg.sv
// Shared types and constants for the serial shift blocks (transmitter and
// its bit counter).
package shift_pkg;

  // Transmitter frame state: nothing in flight, or a word being shifted out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Word length used when a shift block is instantiated without an override.
  localparam int SHIFT_W_DEFAULT = 4;

  // Bit-counter width for a given word length. Never returns less than one
  // bit, so narrow words still get a usable counter register.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit position counter for a WIDTH-bit word: counts 0..WIDTH-1, saturates at
// WIDTH-1 and raises 'last_o' there. A synchronous clear returns it to zero
// and takes priority over counting.
module bit_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_W_DEFAULT,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_o = (cnt_q == LAST_VAL);

  // Next count: clear wins, otherwise advance until the last bit position.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !last_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter. Takes a word on a valid/ready load,
// then shifts it out MSB first, one bit per clock, with a frame-valid
// qualifier and a done pulse on the last bit. A new word can be accepted on
// the last-bit cycle so consecutive words stream with no gap.
module piso_tx
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic             last;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_en;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .last_o  (last)
  );

  // Ready when idle, or on the last bit of the current word so the next
  // word can follow without a gap.
  assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && last);
  assign accept     = load_valid && load_ready;

  assign sout       = sr_q[WIDTH-1];
  assign sout_valid = (state_q == SHIFT);
  assign done       = (state_q == SHIFT) && last;

  // Next-state, shift-register and counter control decisions.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d      = din;
          cnt_clear = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!last) begin
          sr_d   = {sr_q[WIDTH-2:0], 1'b0};
          cnt_en = 1'b1;
        end else if (accept) begin
          sr_d      = din;
          cnt_clear = 1'b1;
        end else begin
          sr_d      = '0;
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        sr_d      = '0;
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // State register; reset abandons any word in flight immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift register holding the remaining bits of the current word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a 4-bit instance checked cycle by cycle against a
// bit-queue model, plus an 8-bit instance looped back into a serial-in
// receiver register.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       reset_n;

  logic [3:0] din4;
  logic       lv4;
  logic       ready4;
  logic       sout4;
  logic       sv4;
  logic       done4;

  logic [7:0] din8;
  logic       lv8;
  logic       ready8;
  logic       sout8;
  logic       sv8;
  logic       done8;
  logic [7:0] rx;

  int vectors     = 0;
  int miscompares = 0;

  // Bits still to appear on the 4-bit instance's serial output, front is the
  // bit on the wire this cycle.
  bit expQ[$];

  logic [3:0] words [3] = '{4'hA, 4'h5, 4'hF};
  int         idx;
  int         lat;
  int         seen;
  logic [7:0] w8;

  piso_tx #(.WIDTH(4)) u4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din4),
    .load_valid (lv4),
    .load_ready (ready4),
    .sout       (sout4),
    .sout_valid (sv4),
    .done       (done4)
  );

  piso_tx #(.WIDTH(8)) u8 (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din8),
    .load_valid (lv8),
    .load_ready (ready8),
    .sout       (sout8),
    .sout_valid (sv8),
    .done       (done8)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Serial-in receiver for the 8-bit instance: shifts in only framed bits.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx <= '0;
    end else if (sv8) begin
      rx <= {rx[6:0], sout8};
    end
  end

  // Safety net so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One-bit comparison, counted and reported.
  task automatic check1(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Integer comparison, counted and reported.
  task automatic checkVal(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Compare all 4-bit instance outputs with what the bit queue predicts.
  task automatic checkOutput(input string ctx);
    logic eValid;
    logic eBit;
    logic eDone;
    logic eReady;
    eValid = (expQ.size() > 0);
    eBit   = eValid ? expQ[0] : 1'b0;
    eDone  = (expQ.size() == 1);
    eReady = (expQ.size() <= 1);
    check1({ctx, ".sout"},       sout4,  eBit);
    check1({ctx, ".sout_valid"}, sv4,    eValid);
    check1({ctx, ".done"},       done4,  eDone);
    check1({ctx, ".load_ready"}, ready4, eReady);
  endtask

  // Drive one cycle from the falling edge, check outputs, then advance the
  // model across the rising edge: the current bit leaves, and an accepted
  // word appends its bits MSB first.
  task automatic applyStimulus(input logic lv, input logic [3:0] d, input string ctx);
    bit rdy;
    lv4  = lv;
    din4 = d;
    #1;
    checkOutput(ctx);
    rdy = (expQ.size() <= 1);
    @(posedge clk);
    if (expQ.size() > 0) void'(expQ.pop_front());
    if (lv && rdy) begin
      for (int i = 3; i >= 0; i--) expQ.push_back(d[i]);
    end
    @(negedge clk);
  endtask

  // Directed and random sequence.
  initial begin
    reset_n = 1'b0;
    lv4     = 1'b0;
    din4    = '0;
    lv8     = 1'b0;
    din8    = '0;

    // Reset state of both instances.
    #2;
    checkOutput("reset");
    check1("reset8.load_ready", ready8, 1'b1);
    check1("reset8.sout_valid", sv8, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single word 1011 with a one-cycle load pulse.
    applyStimulus(1'b1, 4'b1011, "single.acc");
    repeat (5) applyStimulus(1'b0, 4'($urandom), "single");

    // Back-to-back words with load_valid held high.
    idx = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      bit willAccept;
      willAccept = (expQ.size() <= 1);
      applyStimulus(1'b1, words[idx], "b2b");
      if (willAccept) idx++;
    end
    checkVal("b2b.accepted", idx, 3);
    repeat (14) applyStimulus(1'b0, 4'($urandom), "b2b.drain");

    // Stall: load_valid raised mid-word, taken on the last-bit cycle.
    applyStimulus(1'b1, 4'h6, "stall.acc");
    applyStimulus(1'b0, 4'h6, "stall.b1");
    repeat (3) applyStimulus(1'b1, 4'h3, "stall.wait");
    repeat (5) applyStimulus(1'b0, 4'($urandom), "stall.drain");

    // Reset asserted during bit 2 of 4'hC drops outputs without a clock edge.
    applyStimulus(1'b1, 4'hC, "rst.acc");
    applyStimulus(1'b0, 4'h0, "rst.b1");
    lv4 = 1'b0;
    #1;
    checkOutput("rst.b2");
    #1;
    reset_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rst.async");
    @(posedge clk);
    #1;
    checkOutput("rst.held");
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 4'h9, "rst.next");
    repeat (5) applyStimulus(1'b0, 4'($urandom), "rst.drain");

    // Idle with din toggling.
    repeat (10) applyStimulus(1'b0, 4'($urandom), "idle");

    // Random load traffic.
    repeat (60) applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), "rand");
    repeat (5) applyStimulus(1'b0, 4'($urandom), "rand.drain");

    // 8-bit loopback into the receiver register.
    for (int k = 0; k < 4; k++) begin
      w8   = (k == 0) ? 8'hB4 : 8'($urandom);
      lv8  = 1'b1;
      din8 = w8;
      @(posedge clk);
      @(negedge clk);
      lv8  = 1'b0;
      din8 = 8'($urandom);
      lat  = 0;
      seen = 0;
      while (lat < 20 && seen == 0) begin
        if (done8) begin
          seen = 1;
        end else begin
          @(posedge clk);
          @(negedge clk);
          lat++;
        end
      end
      checkVal("lb.done_seen", seen, 1);
      checkVal("lb.latency", lat, 7);
      @(posedge clk);
      @(negedge clk);
      checkVal("lb.rx", int'(rx), int'(w8));
      check1("lb.idle_after", sv8, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock, MSB first, with a frame-valid qualifier. It is the sending end for the team's serial-in shift-register chains: a 4-deep serial-in/serial-out chain driven by this block's `sout` sees the word in the same bit order. Back-to-back words stream without idle gaps.

## Interface
- `WIDTH`, default 4: word length in bits; legal range 2..32.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `din`  input  WIDTH: parallel word; sampled only on an accepted load.
- `load_valid`  input  1: `din` holds a word to transmit.
- `load_ready`  output  1: block can accept a word this cycle.
- `sout`  output  1: serial data bit.
- `sout_valid`  output  1: `sout` carries a frame bit this cycle.
- `done`  output  1: single-cycle pulse coincident with the last bit of each word.

## Operation
- States:
  - IDLE: no word in flight.
  - SHIFT: word being transmitted.
- Datapath:
  - Shift register `sr[WIDTH-1:0]`; `sout = sr[WIDTH-1]`.
  - Bit counter `cnt`, $clog2(WIDTH) bits, counts 0..WIDTH-1 and never wraps past WIDTH-1.
- Load accept = `load_valid && load_ready`.
- `load_ready` is combinational: high in IDLE, or in SHIFT when `cnt == WIDTH-1` (last bit). It is low otherwise.
- IDLE, accept: `sr <= din`, `cnt <= 0`, go to SHIFT.
- IDLE, no accept: hold; `sout_valid = 0`, `sout = 0`.
- SHIFT, `cnt < WIDTH-1`: `sr <= {sr[WIDTH-2:0],1'b0}`, `cnt <= cnt+1`.
- SHIFT, `cnt == WIDTH-1`:
  - With accept: `sr <= din`, `cnt <= 0`, stay in SHIFT (gapless back-to-back).
  - Without accept: go to IDLE; `sr <= 0`.
- `sout_valid = (state == SHIFT)`.
- `done = (state == SHIFT) && (cnt == WIDTH-1)`.
- `din` changing while not accepted has no effect.
- `load_valid` held high with no accept (mid-word) is ignored. The word is taken at the next `load_ready`; no data is lost upstream because the handshake stalls.
- Reset asserted mid-word: the word is abandoned, the block is in IDLE immediately (asynchronous), and no `done` pulse is produced for the partial word.

## Timing
- Reset values: state IDLE, `sr = 0`, `cnt = 0`, `sout = 0`, `sout_valid = 0`, `done = 0`, `load_ready = 1`.
- Reset assertion is asynchronous. Deassertion is expected synchronous to `clk` (synchronized externally); the first accept is possible on the first edge after deassertion.
- Latency: accept at edge N → `sout = din[WIDTH-1]` with `sout_valid = 1` during cycle N+1 → bit `din[0]` during cycle N+WIDTH, with `done = 1` that cycle.
- Throughput: one word per WIDTH cycles when `load_valid` stays high; `sout_valid` is continuously high.
- Word occupancy: exactly WIDTH cycles of `sout_valid` per accepted word, never more or fewer.

## Structure
- Shared package `shift_pkg`:
  - State typedef (IDLE, SHIFT).
  - Default-width constant `SHIFT_W_DEFAULT = 4`.
  - Helper for counter width ($clog2 wrapper guarding WIDTH=2).
- One sub-module is natural: `bit_counter`, a 0..WIDTH-1 up-counter with async active-low clear, synchronous load-to-zero, and a `last` flag. `piso_tx` instantiates it once; `done` and `load_ready` derive from `last`.
- FSM, shift register and output logic stay in `piso_tx`.

## Test plan
- Reset then single word, WIDTH=4, `din = 4'b1011`, `load_valid` pulsed one cycle → `sout` = 1,0,1,1 over cycles N+1..N+4, `sout_valid` high exactly 4 cycles, `done` high only in cycle N+4, `load_ready` back to 1.
- Back-to-back: `load_valid` held high with words 4'hA, 4'h5, 4'hF → serial stream 1010 0101 1111 with no gap; `done` pulses every 4th cycle; `load_ready` high only on last-bit cycles.
- Stall: `load_valid` raised in cycle N+2 of a word with `din = 4'h3` → ignored until the last-bit cycle, accepted there, `0011` follows immediately.
- Reset mid-word: assert `reset_n = 0` during bit 2 of 4'hC → `sout_valid`, `sout` and `done` drop immediately without waiting for `clk`; after release `load_ready = 1` and the next word 4'h9 transmits cleanly as 1001.
- Idle behaviour: no `load_valid` for 10 cycles with `din` toggling randomly → `sout = 0`, `sout_valid = 0`, `done = 0` throughout.
- WIDTH=8 loopback: `sout` fed into an 8-stage serial-in shift register gated by `sout_valid`, `din = 8'hB4` → receiver holds 8'hB4 on the cycle after `done`.
